// File: rtl/pipeline_pkg.sv
// Types and constants shared by the fetch/decode pipeline blocks.
// The NOP encoding is what decode sees whenever the queue has nothing to offer.
package pipeline_pkg;

  localparam logic [31:0] NOP_INSTR  = 32'h00000013;
  localparam int          REG_ADDR_W = 5;
  localparam int          XLEN       = 32;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } fd_entry_t;

endpackage

// File: rtl/fetch_decode_queue.sv
// Small instruction queue between fetch and decode that absorbs decode stalls.
// It presents the head entry, with register-file addresses pre-extracted, to decode.
module fetch_decode_queue
  import pipeline_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2,
  localparam int PTR_W     = $clog2(DEPTH),
  localparam int CNT_W     = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  FlushD_i,
  input  logic                  ValidF_i,
  input  logic [DATA_WIDTH-1:0] InstrF_i,
  input  logic [DATA_WIDTH-1:0] PCF_i,
  input  logic [DATA_WIDTH-1:0] PCPlus4F_i,
  output logic                  ReadyF_o,
  input  logic                  ReadyD_i,
  output logic                  ValidD_o,
  output logic [DATA_WIDTH-1:0] InstrD_o,
  output logic [DATA_WIDTH-1:0] PCD_o,
  output logic [DATA_WIDTH-1:0] PCPlus4D_o,
  output logic [REG_ADDR_W-1:0] A1D_o,
  output logic [REG_ADDR_W-1:0] A2D_o,
  output logic [REG_ADDR_W-1:0] A3D_o,
  output logic [CNT_W-1:0]      Count_o
);

  logic [DATA_WIDTH-1:0] instr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] pc_mem    [DEPTH];
  logic [DATA_WIDTH-1:0] pc4_mem   [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push;
  logic             pop;

  // Ready looks only at occupancy, so a pop never opens a same-cycle refill.
  assign ReadyF_o = (count_q != CNT_W'(DEPTH));
  assign ValidD_o = (count_q != '0);
  assign Count_o  = count_q;

  always_comb begin
    push     = ValidF_i & ReadyF_o & ~FlushD_i;
    pop      = ValidD_o & ReadyD_i & ~FlushD_i;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (FlushD_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage is never reset; the valid gating below hides stale slots.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= InstrF_i;
      pc_mem[wr_ptr_q]    <= PCF_i;
      pc4_mem[wr_ptr_q]   <= PCPlus4F_i;
    end
  end

  assign InstrD_o   = ValidD_o ? instr_mem[rd_ptr_q] : DATA_WIDTH'(NOP_INSTR);
  assign PCD_o      = ValidD_o ? pc_mem[rd_ptr_q]    : '0;
  assign PCPlus4D_o = ValidD_o ? pc4_mem[rd_ptr_q]   : '0;

  assign A1D_o = InstrD_o[19:15];
  assign A2D_o = InstrD_o[24:20];
  assign A3D_o = InstrD_o[11:7];

endmodule
